// File: rtl/icosoc_raspif_pkg.sv
// Shared types and byte codes for the RasPi-interface memory bridge.
package icosoc_raspif_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, WDATA, BUS, RESP} state_t;

  localparam logic [7:0] CMD_WRITE = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] RSP_ACK   = 8'h5A;
  localparam logic [7:0] RSP_ERR   = 8'hEE;

  function automatic logic is_cmd(input logic [7:0] b);
    return (b == CMD_WRITE) || (b == CMD_READ);
  endfunction

endpackage

// File: rtl/icosoc_raspif_membridge_shreg.sv
// 32-bit little-endian byte shift register: bytes enter at the top and leave at [7:0].
// A 2-bit counter tracks shifts; last is high while the fourth byte position is current.
module icosoc_raspif_membridge_shreg (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic [31:0] load_data,
  input  logic [1:0]  load_cnt,
  input  logic        shift,
  input  logic [7:0]  shift_in,
  output logic [31:0] data,
  output logic        last
);

  logic [31:0] data_reg, data_next;
  logic [1:0]  cnt_reg, cnt_next;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] upper;
      if (gi == 3) begin : g_top
        assign upper = shift_in;
      end else begin : g_mid
        assign upper = data_reg[8*gi+15 -: 8];
      end
      assign data_next[8*gi +: 8] = load  ? load_data[8*gi +: 8] :
                                    shift ? upper : data_reg[8*gi +: 8];
    end
  endgenerate

  assign cnt_next = load ? load_cnt : (shift ? cnt_reg + 2'd1 : cnt_reg);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_reg <= '0;
      cnt_reg  <= '0;
    end else begin
      data_reg <= data_next;
      cnt_reg  <= cnt_next;
    end
  end

  assign data = data_reg;
  assign last = (cnt_reg == 2'd3);

endmodule

// File: rtl/icosoc_raspif_membridge.sv
// Byte-command to 32-bit memory bus bridge for the RasPi interface.
// Define ICOSOC_RASPIF_MEMBRIDGE_TIMEOUT_EN to abort stalled bus requests after TIMEOUT_CYCLES.
module icosoc_raspif_membridge
  import icosoc_raspif_pkg::*;
#(
  parameter int WRITE_ACK      = 1,
  parameter int TIMEOUT_CYCLES = 1023
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        sync,
  input  logic        recv_valid,
  output logic        recv_ready,
  input  logic [7:0]  recv_tdata,
  output logic        send_valid,
  input  logic        send_ready,
  output logic [7:0]  send_tdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata
);

  state_t      state_reg;
  logic        started_reg, is_write_reg, discard_reg;
  logic        mem_valid_reg, send_valid_reg;
  logic [3:0]  mem_wstrb_reg;
  logic        recv_fire, send_fire, bus_done, bus_discard, tmo_hit;
  logic        addr_load, addr_shift, addr_last, wdata_shift, wdata_last;
  logic        resp_load, resp_shift, resp_last;
  logic [31:0] addr_data, wdata_data, resp_data, resp_load_data;
  logic [1:0]  resp_load_cnt;
  logic [23:0] unused_resp_hi;

  assign recv_ready  = started_reg && !sync &&
                       (state_reg == IDLE || state_reg == ADDR || state_reg == WDATA);
  assign recv_fire   = recv_valid && recv_ready;
  assign send_fire   = send_valid_reg && send_ready;
  assign bus_done    = (state_reg == BUS) && mem_valid_reg && mem_ready;
  assign bus_discard = discard_reg || sync;

  assign addr_load   = (state_reg == IDLE) && recv_fire && is_cmd(recv_tdata);
  assign addr_shift  = (state_reg == ADDR) && recv_fire;
  assign wdata_shift = (state_reg == WDATA) && recv_fire;
  assign resp_shift  = (state_reg == RESP) && send_fire && !resp_last;

  // Single-byte responses preload the counter so last is already set.
  always_comb begin
    resp_load      = 1'b0;
    resp_load_data = {24'h0, RSP_ERR};
    resp_load_cnt  = 2'd3;
    if ((state_reg == IDLE) && recv_fire && !is_cmd(recv_tdata)) begin
      resp_load = 1'b1;
    end else if (bus_done && !is_write_reg) begin
      resp_load      = 1'b1;
      resp_load_data = mem_rdata;
      resp_load_cnt  = 2'd0;
    end else if (bus_done) begin
      resp_load      = 1'b1;
      resp_load_data = {24'h0, RSP_ACK};
    end else if (tmo_hit) begin
      resp_load = 1'b1;
    end
  end

  icosoc_raspif_membridge_shreg u_addr (
    .clk(clk), .resetn(resetn), .load(addr_load), .load_data(32'h0), .load_cnt(2'd0),
    .shift(addr_shift), .shift_in(recv_tdata), .data(addr_data), .last(addr_last)
  );

  icosoc_raspif_membridge_shreg u_wdata (
    .clk(clk), .resetn(resetn), .load(addr_load), .load_data(32'h0), .load_cnt(2'd0),
    .shift(wdata_shift), .shift_in(recv_tdata), .data(wdata_data), .last(wdata_last)
  );

  icosoc_raspif_membridge_shreg u_resp (
    .clk(clk), .resetn(resetn), .load(resp_load), .load_data(resp_load_data),
    .load_cnt(resp_load_cnt), .shift(resp_shift), .shift_in(8'h00),
    .data(resp_data), .last(resp_last)
  );

`ifdef ICOSOC_RASPIF_MEMBRIDGE_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;
  logic [TMO_W-1:0] tmo_cnt_reg;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      tmo_cnt_reg <= '0;
    else if (state_reg != BUS)
      tmo_cnt_reg <= '0;
    else if (mem_valid_reg && !mem_ready)
      tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
  end

  assign tmo_hit = (state_reg == BUS) && mem_valid_reg && !mem_ready &&
                   (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg      <= IDLE;
      started_reg    <= 1'b0;
      is_write_reg   <= 1'b0;
      discard_reg    <= 1'b0;
      mem_valid_reg  <= 1'b0;
      mem_wstrb_reg  <= 4'h0;
      send_valid_reg <= 1'b0;
    end else begin
      started_reg <= 1'b1;
      case (state_reg)
        IDLE: begin
          if (recv_fire) begin
            if (is_cmd(recv_tdata)) begin
              state_reg    <= ADDR;
              is_write_reg <= (recv_tdata == CMD_WRITE);
            end else begin
              state_reg      <= RESP;
              send_valid_reg <= 1'b1;
            end
          end
        end
        ADDR: begin
          if (sync) begin
            state_reg <= IDLE;
          end else if (recv_fire && addr_last) begin
            if (is_write_reg) begin
              state_reg <= WDATA;
            end else begin
              state_reg     <= BUS;
              mem_valid_reg <= 1'b1;
              mem_wstrb_reg <= 4'h0;
              discard_reg   <= 1'b0;
            end
          end
        end
        WDATA: begin
          if (sync) begin
            state_reg <= IDLE;
          end else if (recv_fire && wdata_last) begin
            state_reg     <= BUS;
            mem_valid_reg <= 1'b1;
            mem_wstrb_reg <= 4'hF;
            discard_reg   <= 1'b0;
          end
        end
        BUS: begin
          // A sync here lets the bus cycle finish but swallows its response.
          if (sync) discard_reg <= 1'b1;
          if (bus_done || tmo_hit) begin
            mem_valid_reg <= 1'b0;
            mem_wstrb_reg <= 4'h0;
            if (bus_discard) begin
              state_reg <= IDLE;
            end else if (tmo_hit || !is_write_reg || (WRITE_ACK != 0)) begin
              state_reg      <= RESP;
              send_valid_reg <= 1'b1;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        RESP: begin
          if (sync || (send_fire && resp_last)) begin
            state_reg      <= IDLE;
            send_valid_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign mem_valid = mem_valid_reg;
  assign mem_wstrb = mem_wstrb_reg;
  assign mem_addr  = addr_data & 32'hFFFF_FFFC;
  assign mem_wdata = wdata_data;
  assign send_valid = send_valid_reg;
  assign {unused_resp_hi, send_tdata} = resp_data;

endmodule
